// File: rtl/fetch_queue.sv
// Instruction fetch queue: FWFT FIFO between fetch and decode with head-entry field decode.
// Flush discards all entries at the next edge; reset discards them immediately.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [5:0]  out_opcode,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic        out_is_branch,
    output logic        out_is_jump,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head_instr;
    logic [31:0]   w_head_pc;
    logic [5:0]    w_opcode;
    logic          w_zero_ext;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage is not reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wptr] <= in_instr;
            r_pc[r_wptr]    <= in_pc;
        end
    end

    // Head entry masked to a NOP when the queue is empty.
    always_comb begin
        w_head_instr = '0;
        w_head_pc    = '0;
        if (out_valid) begin
            w_head_instr = r_instr[r_rptr];
            w_head_pc    = r_pc[r_rptr];
        end
    end

    assign w_opcode   = w_head_instr[31:26];
    assign w_zero_ext = (w_opcode == 6'h0C) || (w_opcode == 6'h0D) || (w_opcode == 6'h0E);

    assign out_instr     = w_head_instr;
    assign out_pc        = w_head_pc;
    assign out_opcode    = w_opcode;
    assign out_rs        = w_head_instr[25:21];
    assign out_rt        = w_head_instr[20:16];
    assign out_rd        = w_head_instr[15:11];
    assign out_imm       = w_zero_ext ? {16'h0000, w_head_instr[15:0]}
                                      : {{16{w_head_instr[15]}}, w_head_instr[15:0]};
    assign out_is_branch = (w_opcode == 6'h04) || (w_opcode == 6'h05);
    assign out_is_jump   = (w_opcode == 6'h02) || (w_opcode == 6'h03);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): one task per scenario, inline comparisons.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_is_branch;
    logic        out_is_jump;
    logic [2:0]  count;

    int n_vec;
    int n_err;

    fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
        .out_is_branch(out_is_branch), .out_is_jump(out_is_jump), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_queue();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if (out_instr !== 32'h0 || out_imm !== 32'h0 || out_pc !== 32'h0) begin
            n_err++; $display("FAIL reset_data got instr=%h pc=%h imm=%h want 0", out_instr, out_pc, out_imm);
        end
        rst = 1'b1;
    endtask

    task automatic test_first_push();
        push(32'h8C220004, 32'h00400000);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lw_out_valid got %0b want 1", out_valid); end
        n_vec++; if (out_opcode !== 6'h23) begin n_err++; $display("FAIL lw_opcode got %h want 23", out_opcode); end
        n_vec++; if (out_rs !== 5'd1 || out_rt !== 5'd2) begin n_err++; $display("FAIL lw_regs got rs=%0d rt=%0d want 1 2", out_rs, out_rt); end
        n_vec++; if (out_imm !== 32'h00000004) begin n_err++; $display("FAIL lw_imm got %h want 00000004", out_imm); end
        n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL lw_count got %0d want 1", count); end
        n_vec++; if (out_pc !== 32'h00400000) begin n_err++; $display("FAIL lw_pc got %h want 00400000", out_pc); end
        clear_queue();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) push({16'hA000, 16'(i)}, 32'(i * 4));
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %0b want 0", in_ready); end
        push(32'hDEADBEEF, 32'h00000010);
        n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL overflow_count got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (out_pc !== 32'(i * 4) || out_instr !== {16'hA000, 16'(i)}) begin
                n_err++; $display("FAIL drain_%0d got pc=%h instr=%h want pc=%h", i, out_pc, out_instr, 32'(i * 4));
            end
            step();
        end
        out_ready = 1'b0;
        n_vec++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL drained_empty got count=%0d valid=%0b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        push(32'h00000100, 32'h00000100);
        push(32'h00000104, 32'h00000104);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_instr = 32'(32'h108 + 4 * k); in_pc = 32'(32'h108 + 4 * k);
            n_vec++; if (out_pc !== 32'(32'h100 + 4 * k)) begin
                n_err++; $display("FAIL b2b_head_%0d got %h want %h", k, out_pc, 32'(32'h100 + 4 * k));
            end
            step();
            n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count_%0d got %0d want 2", k, count); end
        end
        in_valid = 1'b0;
        n_vec++; if (out_pc !== 32'h00000128) begin n_err++; $display("FAIL b2b_tail got %h want 00000128", out_pc); end
        step();
        n_vec++; if (out_pc !== 32'h0000012C) begin n_err++; $display("FAIL b2b_last got %h want 0000012c", out_pc); end
        out_ready = 1'b0;
        clear_queue();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push(32'h00000200 + 32'(i), 32'h00000200 + 32'(i * 4));
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'hCAFEF00D; in_pc = 32'h00000300;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL flush_instr got %h want 0", out_instr); end
        push(32'h00000400, 32'h00000400);
        n_vec++; if (out_pc !== 32'h00000400 || count !== 3'd1) begin
            n_err++; $display("FAIL flush_repush got pc=%h count=%0d want 00000400 1", out_pc, count);
        end
        clear_queue();
    endtask

    task automatic test_decode();
        push(32'h3403FFFF, 32'h0);
        push(32'h2003FFFF, 32'h4);
        push(32'h10220003, 32'h8);
        push(32'h08100000, 32'hC);
        n_vec++; if (out_imm !== 32'h0000FFFF) begin n_err++; $display("FAIL ori_imm got %h want 0000ffff", out_imm); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
        n_vec++; if (out_is_branch !== 1'b0) begin n_err++; $display("FAIL addi_branch got %0b want 0", out_is_branch); end
        step();
        n_vec++; if (out_is_branch !== 1'b1 || out_is_jump !== 1'b0) begin
            n_err++; $display("FAIL beq_flags got br=%0b j=%0b want 1 0", out_is_branch, out_is_jump);
        end
        n_vec++; if (out_rs !== 5'd1 || out_rt !== 5'd2 || out_imm !== 32'h3) begin
            n_err++; $display("FAIL beq_fields got rs=%0d rt=%0d imm=%h want 1 2 3", out_rs, out_rt, out_imm);
        end
        step();
        n_vec++; if (out_is_jump !== 1'b1 || out_is_branch !== 1'b0) begin
            n_err++; $display("FAIL j_flags got j=%0b br=%0b want 1 0", out_is_jump, out_is_branch);
        end
        step();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_is_jump !== 1'b0 || out_opcode !== 6'h0) begin
            n_err++; $display("FAIL empty_nop got valid=%0b imm=%h j=%0b op=%h want 0", out_valid, out_imm, out_is_jump, out_opcode);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push(32'h00000500 + 32'(i), 32'h00000500 + 32'(i * 4));
        n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL prereset_count got %0d want 3", count); end
        #3 rst = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_err++; $display("FAIL async_reset got valid=%0b count=%0d want 0 0", out_valid, count);
        end
        n_vec++; if (in_ready !== 1'b1 || out_pc !== 32'h0) begin
            n_err++; $display("FAIL async_reset_out got ready=%0b pc=%h want 1 0", in_ready, out_pc);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL post_release_count got %0d want 0", count); end
        push(32'h00000600, 32'h00000600);
        n_vec++; if (out_valid !== 1'b1 || count !== 3'd1 || out_instr !== 32'h00000600) begin
            n_err++; $display("FAIL post_reset_push got valid=%0b count=%0d instr=%h want 1 1 00000600", out_valid, count, out_instr);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_first_push();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_decode();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  fetch stage presents an instruction.
REQ-005 in_instr  input  32  instruction word from the fetch unit.
REQ-006 in_pc  input  32  byte address of in_instr, low two bits zero.
REQ-007 in_ready  output  1  queue accepts a push this cycle.
REQ-008 flush  input  1  discard all entries on a taken branch or jump.
REQ-009 out_ready  input  1  decode stage consumes the head this cycle.
REQ-010 out_valid  output  1  head entry is valid.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc  output  32  head PC.
REQ-013 out_opcode  output  6  head instr[31:26].
REQ-014 out_rs, out_rt, out_rd  output  5 each  head instr[25:21], [20:16], [15:11].
REQ-015 out_imm  output  32  head immediate, extended per REQ-027.
REQ-016 out_is_branch  output  1  head opcode is 6'h04 or 6'h05.
REQ-017 out_is_jump  output  1  head opcode is 6'h02 or 6'h03.
REQ-018 count  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-019 Push SHALL occur when in_valid && in_ready && !flush; entry written at write pointer, pointer advanced.
REQ-020 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend on out_ready, so a full queue refuses a push even when popping.
REQ-021 Pop SHALL occur when out_valid && out_ready && !flush; read pointer advanced.
REQ-022 out_valid SHALL equal (count != 0); storage is first-word-fall-through with no combinational input-to-output bypass.
REQ-023 Latency: an instruction pushed at edge N SHALL appear on out_* after edge N, i.e. out_valid high in cycle N+1 if queue was empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or fall below 0.
REQ-026 flush SHALL, at the next rising edge, set count and both pointers to 0; any push or pop in that cycle is discarded; flush has priority over push and pop.
REQ-027 out_imm SHALL be zero-extended instr[15:0] when opcode is 6'h0C, 6'h0D or 6'h0E, otherwise sign-extended.
REQ-028 When count == 0, out_instr, out_pc, out_imm and all decoded fields SHALL read 0 (NOP), out_is_branch and out_is_jump 0.
REQ-029 Decoded outputs SHALL be combinational functions of the registered head entry only.
REQ-030 Behaviour with in_valid high while in_ready low SHALL be no state change; the producer holds its data.

Reset
REQ-031 While rst is 0: count = 0, pointers = 0, out_valid = 0, in_ready = 1, all data outputs 0, independent of clk.
REQ-032 Deassertion of rst SHALL take effect without a clock edge; first push is accepted at the first rising edge with rst = 1.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately; entry storage contents need not be cleared.

Verification
REQ-034 Push 0x8C220004 @ pc 0x00400000 into empty queue, out_ready=0 -> next cycle out_valid=1, out_opcode=6'h23, out_rs=1, out_rt=2, out_imm=0x00000004, count=1.
REQ-035 Push 4 entries (pc 0x00, 0x04, 0x08, 0x0C), out_ready=0 -> count=4, in_ready=0; fifth push held and not stored; then out_ready=1 for 4 cycles pops pc 0x00,0x04,0x08,0x0C in order.
REQ-036 With count=2, push and pop in the same cycle repeatedly for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-037 With count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_instr=0, pushed word absent.
REQ-038 Push 0x3403FFFF (ori) then 0x2003FFFF (addi) -> out_imm 0x0000FFFF then 0xFFFFFFFF; push 0x10220003 -> out_is_branch=1; push 0x08100000 -> out_is_jump=1.
REQ-039 Assert rst low between edges with count=3 -> out_valid=0, count=0 immediately; after release, single push yields out_valid=1 one cycle later.
